// File: rtl/rvc_asap_pkg.sv
// ---------------------------------------------------------------------------
// rvc_asap_pkg
//   Shared types for the CR-memory port arbiter.
//   - t_cr_id  : identifies the requester that owns an access (core / aux).
//   - t_cr_req : one requester's access bundle {req, wr_en, addr, wr_data}.
//   - cr_pick  : selects the granted requester's bundle onto the CR port.
// ---------------------------------------------------------------------------
package rvc_asap_pkg;

    localparam int CR_ADDR_W = 32;
    localparam int CR_DATA_W = 32;

    typedef enum logic {
        CR_ID_CORE = 1'b0,
        CR_ID_AUX  = 1'b1
    } t_cr_id;

    typedef struct packed {
        logic                 req;
        logic                 wr_en;
        logic [CR_ADDR_W-1:0] addr;
        logic [CR_DATA_W-1:0] wr_data;
    } t_cr_req;

    // Grants are one-hot or zero. With no grant the CR port is driven to all
    // zeros, so neither enable can fire and address/data stay quiet.
    function automatic t_cr_req cr_pick(input logic    gnt_core,
                                        input logic    gnt_aux,
                                        input t_cr_req core,
                                        input t_cr_req aux);
        t_cr_req r;
        r = '0;
        if (gnt_core) begin
            r = core;
        end else if (gnt_aux) begin
            r = aux;
        end
        return r;
    endfunction

endpackage

// File: rtl/rvc_asap_cr_arb_starve.sv
// ---------------------------------------------------------------------------
// rvc_asap_cr_arb_starve
//   Starvation counter and aux-win decision for a two-port arbiter where the
//   core has priority. After STARVE_LIMIT consecutive core grants with aux
//   waiting, aux wins the next contended cycle.
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   core_req_i      core is requesting this cycle
//   aux_req_i       aux is requesting this cycle
//   aux_win_o       aux owns the port this cycle (combinational)
//   starve_cnt_o    current count of core grants while aux waited
// ---------------------------------------------------------------------------
module rvc_asap_cr_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       core_req_i,
    input  logic       aux_req_i,
    output logic       aux_win_o,
    output logic [3:0] starve_cnt_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Aux wins when uncontended, or when it has waited out the limit.
    assign aux_win_o = aux_req_i & (~core_req_i | (cnt_q == LIMIT));

    // The count only advances while aux is waiting, which implies the core
    // was granted. An aux grant or an aux withdrawal resets it. Reaching
    // LIMIT forces an aux win, so the guard only keeps the counter bounded.
    always_comb begin
        cnt_d = cnt_q;
        if (!aux_req_i || aux_win_o) begin
            cnt_d = '0;
        end else if (cnt_q < LIMIT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_cnt_o = cnt_q;

endmodule

// File: rtl/rvc_asap_5pl_cr_arb.sv
// ---------------------------------------------------------------------------
// rvc_asap_5pl_cr_arb
//   Shares the single CR-memory access port between the core memory stage
//   (port 0) and an auxiliary master (port 1). One access is issued per
//   cycle; read data returns to the issuer one cycle later; the core is
//   stalled in any cycle it requests but is not granted.
//
// Handshake: a requester raises *_req_i and holds wr_en/addr/wr_data stable
//   until it sees *_gnt_o high. Grant is combinational and the access is
//   issued on the CR port in the same cycle. Reads return *_rd_valid_o for
//   exactly one cycle, one cycle after the grant; writes return nothing.
//
// Ports
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   core_req_i/_wr_en_i/_addr_i/_wr_data_i   core access request
//   core_gnt_o, core_stall_o       core grant / pipeline freeze
//   core_rd_valid_o, core_rd_data_o          core load return
//   aux_req_i/_wr_en_i/_addr_i/_wr_data_i    aux access request
//   aux_gnt_o                      aux grant
//   aux_rd_valid_o, aux_rd_data_o  aux read return
//   cr_addr_o, cr_wr_data_o, cr_wr_en_o, cr_rd_en_o   to CR memory
//   cr_rd_data_i                   CR memory registered read data
//   dbg_starve_cnt_o               starvation counter, for observation
// ---------------------------------------------------------------------------
module rvc_asap_5pl_cr_arb
    import rvc_asap_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              core_req_i,
    input  logic              core_wr_en_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wr_data_i,
    output logic              core_gnt_o,
    output logic              core_stall_o,
    output logic              core_rd_valid_o,
    output logic [DATA_W-1:0] core_rd_data_o,

    input  logic              aux_req_i,
    input  logic              aux_wr_en_i,
    input  logic [ADDR_W-1:0] aux_addr_i,
    input  logic [DATA_W-1:0] aux_wr_data_i,
    output logic              aux_gnt_o,
    output logic              aux_rd_valid_o,
    output logic [DATA_W-1:0] aux_rd_data_o,

    output logic [ADDR_W-1:0] cr_addr_o,
    output logic [DATA_W-1:0] cr_wr_data_o,
    output logic              cr_wr_en_o,
    output logic              cr_rd_en_o,
    input  logic [DATA_W-1:0] cr_rd_data_i,

    output logic [3:0]        dbg_starve_cnt_o
);

    logic    aux_win;
    logic    core_gnt;
    logic    aux_gnt;
    t_cr_req core_r;
    t_cr_req aux_r;
    t_cr_req sel_r;

    logic    rd_pend_q;
    logic    rd_pend_d;
    t_cr_id  rd_id_q;
    t_cr_id  rd_id_d;

    // ---------------- arbitration ----------------
    rvc_asap_cr_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .aux_req_i    (aux_req_i),
        .aux_win_o    (aux_win),
        .starve_cnt_o (dbg_starve_cnt_o)
    );

    assign aux_gnt  = aux_win;
    assign core_gnt = core_req_i & ~aux_win;

    assign core_gnt_o   = core_gnt;
    assign aux_gnt_o    = aux_gnt;
    assign core_stall_o = core_req_i & ~core_gnt;

    // ---------------- CR port mux ----------------
    always_comb begin
        core_r.req     = core_req_i;
        core_r.wr_en   = core_wr_en_i;
        core_r.addr    = CR_ADDR_W'(core_addr_i);
        core_r.wr_data = CR_DATA_W'(core_wr_data_i);
        aux_r.req      = aux_req_i;
        aux_r.wr_en    = aux_wr_en_i;
        aux_r.addr     = CR_ADDR_W'(aux_addr_i);
        aux_r.wr_data  = CR_DATA_W'(aux_wr_data_i);
    end

    assign sel_r = cr_pick(core_gnt, aux_gnt, core_r, aux_r);

    // sel_r.req is high only when a grant exists, so it gates both enables.
    assign cr_addr_o    = ADDR_W'(sel_r.addr);
    assign cr_wr_data_o = DATA_W'(sel_r.wr_data);
    assign cr_wr_en_o   = sel_r.req & sel_r.wr_en;
    assign cr_rd_en_o   = sel_r.req & ~sel_r.wr_en;

    // ---------------- read return ----------------
    // Track who issued this cycle's read; the memory's registered data lands
    // next cycle and is steered by the recorded id. Loaded every cycle, so
    // back-to-back reads from either port need no bubbles.
    assign rd_pend_d = cr_rd_en_o;
    assign rd_id_d   = aux_gnt ? CR_ID_AUX : CR_ID_CORE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pend_q <= 1'b0;
            rd_id_q   <= CR_ID_CORE;
        end else begin
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    assign core_rd_valid_o = rd_pend_q & (rd_id_q == CR_ID_CORE);
    assign aux_rd_valid_o  = rd_pend_q & (rd_id_q == CR_ID_AUX);
    assign core_rd_data_o  = cr_rd_data_i;
    assign aux_rd_data_o   = cr_rd_data_i;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// ---------------------------------------------------------------------------
// tb_rvc_asap_5pl_cr_arb
//   Directed bench for the CR-port arbiter with a small registered CR memory
//   model. The driver checks grants/CR port in the issue cycle and queues the
//   expected read data plus the cycle it must return in; a monitor pops and
//   compares on every *_rd_valid_o.
// ---------------------------------------------------------------------------
module tb_rvc_asap_5pl_cr_arb;

  localparam logic [31:0] CR_LED      = 32'h0;
  localparam logic [31:0] CR_SWITCH   = 32'h1;
  localparam logic [31:0] CR_CURSOR_H = 32'h2;
  localparam logic [31:0] CR_SEG7_0   = 32'h3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        core_req, core_wr_en, core_gnt, core_stall, core_rd_valid;
  logic [31:0] core_addr, core_wr_data, core_rd_data;
  logic        aux_req, aux_wr_en, aux_gnt, aux_rd_valid;
  logic [31:0] aux_addr, aux_wr_data, aux_rd_data;
  logic [31:0] cr_addr, cr_wr_data, cr_rd_data;
  logic        cr_wr_en, cr_rd_en;
  logic [3:0]  dbg_cnt;

  rvc_asap_5pl_cr_arb #(
    .STARVE_LIMIT (4),
    .ADDR_W       (32),
    .DATA_W       (32)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .core_req_i       (core_req),
    .core_wr_en_i     (core_wr_en),
    .core_addr_i      (core_addr),
    .core_wr_data_i   (core_wr_data),
    .core_gnt_o       (core_gnt),
    .core_stall_o     (core_stall),
    .core_rd_valid_o  (core_rd_valid),
    .core_rd_data_o   (core_rd_data),
    .aux_req_i        (aux_req),
    .aux_wr_en_i      (aux_wr_en),
    .aux_addr_i       (aux_addr),
    .aux_wr_data_i    (aux_wr_data),
    .aux_gnt_o        (aux_gnt),
    .aux_rd_valid_o   (aux_rd_valid),
    .aux_rd_data_o    (aux_rd_data),
    .cr_addr_o        (cr_addr),
    .cr_wr_data_o     (cr_wr_data),
    .cr_wr_en_o       (cr_wr_en),
    .cr_rd_en_o       (cr_rd_en),
    .cr_rd_data_i     (cr_rd_data),
    .dbg_starve_cnt_o (dbg_cnt)
  );

  // ---------------- CR memory model (registered read) ----------------
  logic [31:0] mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0]     <= 32'h155;
      mem[1]     <= 32'h3FF;
      mem[2]     <= 32'h12;
      cr_rd_data <= 32'h0;
    end else begin
      if (cr_wr_en) mem[cr_addr[3:0]] <= cr_wr_data;
      if (cr_rd_en) cr_rd_data <= mem[cr_addr[3:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_core_q[$];
  logic [31:0] exp_core_cyc_q[$];
  logic [31:0] exp_aux_q[$];
  logic [31:0] exp_aux_cyc_q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void chk1(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] d;
    logic [31:0] c;
    if (core_rd_valid) begin
      if (exp_core_q.size() == 0) begin
        chk1("core_rd_valid_unexpected", core_rd_valid, 1'b0);
      end else begin
        d = exp_core_q.pop_front();
        c = exp_core_cyc_q.pop_front();
        chk("core_rd_data", core_rd_data, d);
        chk("core_rd_cycle", 32'(cyc), c);
      end
    end else if (exp_core_cyc_q.size() != 0 && exp_core_cyc_q[0] < 32'(cyc)) begin
      void'(exp_core_q.pop_front());
      void'(exp_core_cyc_q.pop_front());
      chk1("core_rd_valid_missing", core_rd_valid, 1'b1);
    end
    if (aux_rd_valid) begin
      if (exp_aux_q.size() == 0) begin
        chk1("aux_rd_valid_unexpected", aux_rd_valid, 1'b0);
      end else begin
        d = exp_aux_q.pop_front();
        c = exp_aux_cyc_q.pop_front();
        chk("aux_rd_data", aux_rd_data, d);
        chk("aux_rd_cycle", 32'(cyc), c);
      end
    end else if (exp_aux_cyc_q.size() != 0 && exp_aux_cyc_q[0] < 32'(cyc)) begin
      void'(exp_aux_q.pop_front());
      void'(exp_aux_cyc_q.pop_front());
      chk1("aux_rd_valid_missing", aux_rd_valid, 1'b1);
    end
  end

  // ---------------- driver ----------------
  // One cycle: drive at negedge, check the combinational issue-cycle outputs
  // against the hand-given grant, queue expected read returns for next cycle.
  task automatic step(input string nm,
                      input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                      input logic eg_c, input logic eg_a,
                      input logic [31:0] ed_c, input logic [31:0] ed_a,
                      input bit ret);
    @(negedge clk);
    core_req = cr; core_wr_en = cw; core_addr = ca; core_wr_data = cd;
    aux_req  = ar; aux_wr_en  = aw; aux_addr  = aa; aux_wr_data  = ad;
    #1;
    chk1({nm, "/core_gnt"},   core_gnt,   eg_c);
    chk1({nm, "/aux_gnt"},    aux_gnt,    eg_a);
    chk1({nm, "/core_stall"}, core_stall, cr & ~eg_c);
    chk1({nm, "/cr_wr_en"},   cr_wr_en,   (eg_c & cw) | (eg_a & aw));
    chk1({nm, "/cr_rd_en"},   cr_rd_en,   (eg_c & ~cw) | (eg_a & ~aw));
    chk({nm, "/cr_addr"}, cr_addr, eg_c ? ca : (eg_a ? aa : 32'h0));
    if (ret && eg_c && !cw) begin
      exp_core_q.push_back(ed_c);
      exp_core_cyc_q.push_back(32'(cyc + 1));
    end
    if (ret && eg_a && !aw) begin
      exp_aux_q.push_back(ed_a);
      exp_aux_cyc_q.push_back(32'(cyc + 1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    core_req = 0; core_wr_en = 0; core_addr = 0; core_wr_data = 0;
    aux_req  = 0; aux_wr_en  = 0; aux_addr  = 0; aux_wr_data  = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset state; grants still follow requests combinationally.
    @(negedge clk);
    chk1("rst/core_rd_valid", core_rd_valid, 1'b0);
    chk1("rst/aux_rd_valid",  aux_rd_valid,  1'b0);
    chk("rst/starve_cnt", 32'(dbg_cnt), 32'h0);
    step("rst_gnt", 1, 0, CR_LED, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    core_req = 0;
    rst_n = 1'b1;
    idle(2);

    // 1: core-only load of LED.
    step("t1", 1, 0, CR_LED, 0, 0, 0, 0, 0, 1, 0, 32'h155, 0, 1);
    idle(1);

    // 2: continuous contention, C,C,C,C,A twice.
    for (int i = 0; i < 10; i++) begin
      step("t2", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0,
           (i % 5) != 4, (i % 5) == 4, 32'h155, 32'h12, 1);
    end
    idle(1);

    // 3: aux read then core read back to back.
    step("t3a", 0, 0, 0, 0, 1, 0, CR_CURSOR_H, 0, 0, 1, 0, 32'h12, 1);
    step("t3c", 1, 0, CR_SWITCH, 0, 0, 0, 0, 0, 1, 0, 32'h3FF, 0, 1);
    idle(2);

    // 4: aux write then core read of the same entry.
    step("t4w", 0, 0, 0, 0, 1, 1, CR_SEG7_0, 32'hA5, 0, 1, 0, 0, 1);
    step("t4r", 1, 0, CR_SEG7_0, 0, 0, 0, 0, 0, 1, 0, 32'hA5, 0, 1);
    idle(1);

    // 5: reset hits while an aux read is in flight (counter at limit).
    for (int i = 0; i < 4; i++) begin
      step("t5c", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 1, 0, 32'h155, 0, 1);
    end
    step("t5a", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 0, 1, 0, 32'h12, 0);
    chk("t5/cnt_before_rst", 32'(dbg_cnt), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("t5/cnt_in_rst", 32'(dbg_cnt), 32'h0);
    core_req = 0; aux_req = 0;
    repeat (2) @(negedge clk);
    chk1("t5/aux_rd_valid_in_rst", aux_rd_valid, 1'b0);
    rst_n = 1'b1;
    idle(3);
    chk("t5/cnt_after_rst", 32'(dbg_cnt), 32'h0);

    // 6: aux withdraws exactly when the counter sits at the limit.
    for (int i = 0; i < 4; i++) begin
      step("t6c", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 1, 0, 32'h155, 0, 1);
    end
    step("t6drop", 1, 0, CR_LED, 0, 0, 0, 0, 0, 1, 0, 32'h155, 0, 1);
    chk("t6/cnt_at_limit", 32'(dbg_cnt), 32'h4);
    step("t6r0", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 1, 0, 32'h155, 0, 1);
    chk("t6/cnt_cleared", 32'(dbg_cnt), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step("t6r", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 1, 0, 32'h155, 0, 1);
    end
    step("t6a", 1, 0, CR_LED, 0, 1, 0, CR_CURSOR_H, 0, 0, 1, 0, 32'h12, 1);
    idle(3);

    chk("end/core_q_empty", 32'(exp_core_q.size()), 32'h0);
    chk("end/aux_q_empty",  32'(exp_aux_q.size()),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
